// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: priority memory freeze > redirect > load-use.
// Controls are combinational from state and inputs; the wait/flush FSM and counters update on clk.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_memread,
    input  logic             EX_redirect,
    input  logic             MEM_req,
    input  logic             MEM_ack,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             EX_stall,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_stall,
    output logic             MEM_WB_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

    localparam logic [3:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d, base_st;
    logic             ret_flush_q, ret_flush_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic freeze, load_use, redir;

    assign freeze   = MEM_req & ~MEM_ack;
    assign load_use = ID_EX_memread & (ID_EX_rd != 5'd0) &
                      ((ID_uses_rs1 & (ID_rs1 == ID_EX_rd)) |
                       (ID_uses_rs2 & (ID_rs2 == ID_EX_rd)));

    // A released MEM_WAIT behaves as the state it interrupted, so the release cycle is a real flush cycle.
    always_comb begin
        base_st = state_q;
        if (state_q == MEM_WAIT) begin
            base_st = ret_flush_q ? FLUSH : RUN;
        end
    end

    assign redir = EX_redirect | (base_st == FLUSH);

    always_comb begin
        PC_stall      = 1'b0;
        IF_ID_stall   = 1'b0;
        IF_ID_flush   = 1'b0;
        EX_stall      = 1'b0;
        ID_EX_bubble  = 1'b0;
        EX_MEM_stall  = 1'b0;
        MEM_WB_bubble = 1'b0;
        if (!reset) begin
            if (freeze) begin
                PC_stall      = 1'b1;
                IF_ID_stall   = 1'b1;
                EX_stall      = 1'b1;
                EX_MEM_stall  = 1'b1;
                MEM_WB_bubble = 1'b1;
            end else if (redir) begin
                IF_ID_flush   = 1'b1;
                ID_EX_bubble  = 1'b1;
            end else if (load_use) begin
                PC_stall      = 1'b1;
                IF_ID_stall   = 1'b1;
                ID_EX_bubble  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_flush_d = ret_flush_q;
        flush_cnt_d = flush_cnt_q;
        if (freeze) begin
            state_d     = MEM_WAIT;
            ret_flush_d = (base_st == FLUSH);
        end else if (EX_redirect && FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
        end else if (base_st == FLUSH) begin
            if (flush_cnt_q == 4'd0) begin
                state_d = RUN;
            end else begin
                state_d     = FLUSH;
                flush_cnt_d = flush_cnt_q - 4'd1;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_comb begin
        wait_cnt_d  = 8'd0;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        if (freeze) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
            if (wait_cnt_q == TIMEOUT_LAST) begin
                timeout_d = 1'b1;
            end
        end
        if (PC_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            ret_flush_q <= 1'b0;
            flush_cnt_q <= 4'd0;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_flush_q <= ret_flush_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=4.
// Control outputs are compared as {PC, IF_ID stall, IF_ID flush, EX stall, ID_EX bubble, EX_MEM stall, MEM_WB bubble}.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  ID_rs1 = '0, ID_rs2 = '0, ID_EX_rd = '0;
    logic        ID_uses_rs1 = 1'b0, ID_uses_rs2 = 1'b0, ID_EX_memread = 1'b0;
    logic        EX_redirect = 1'b0, MEM_req = 1'b0, MEM_ack = 1'b0;
    logic        PC_stall, IF_ID_stall, IF_ID_flush, EX_stall, ID_EX_bubble;
    logic        EX_MEM_stall, MEM_WB_bubble, mem_timeout;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] FRZ  = 7'b1101011;
    localparam logic [6:0] RDR  = 7'b0010100;
    localparam logic [6:0] LU   = 7'b1100100;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_EX_rd(ID_EX_rd), .ID_EX_memread(ID_EX_memread),
        .EX_redirect(EX_redirect), .MEM_req(MEM_req), .MEM_ack(MEM_ack),
        .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
        .EX_stall(EX_stall), .ID_EX_bubble(ID_EX_bubble), .EX_MEM_stall(EX_MEM_stall),
        .MEM_WB_bubble(MEM_WB_bubble), .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [6:0] exp);
        #1;
        chk(tag, {25'd0, PC_stall, IF_ID_stall, IF_ID_flush, EX_stall,
                  ID_EX_bubble, EX_MEM_stall, MEM_WB_bubble}, {25'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ld();
        ID_EX_memread = 1'b0; ID_EX_rd = '0; ID_rs1 = '0; ID_rs2 = '0;
        ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
    endtask

    initial begin
        // Reset state, with a freeze pending on the inputs to show gating
        MEM_req = 1'b1;
        #2;
        chk_ctrl("reset_ctrl", NONE);
        chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
        chk("reset_count", {16'd0, stall_count}, 32'd0);
        MEM_req = 1'b0;
        #9 reset = 1'b0;
        tick();

        // Load-use through rs1, then the bubble reaches EX
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd5; ID_rs1 = 5'd5; ID_uses_rs1 = 1'b1;
        chk_ctrl("lu_rs1", LU);
        tick();
        ID_EX_memread = 1'b0;
        chk_ctrl("lu_cleared", NONE);
        chk("lu_count", {16'd0, stall_count}, 32'd1);
        tick();
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd0; ID_rs1 = 5'd0;
        chk_ctrl("lu_rd_zero", NONE);
        ID_EX_rd = 5'd5; ID_rs1 = 5'd5; ID_uses_rs1 = 1'b0;
        chk_ctrl("lu_unused_rs1", NONE);
        ID_rs1 = 5'd0; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b1;
        chk_ctrl("lu_rs2", LU);
        tick();
        clear_ld();
        chk("lu_count2", {16'd0, stall_count}, 32'd2);

        // Three-cycle memory freeze then ack
        MEM_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_ctrl($sformatf("frz_%0d", i), FRZ);
            tick();
        end
        MEM_ack = 1'b1;
        chk_ctrl("frz_ack", NONE);
        tick();
        MEM_req = 1'b0; MEM_ack = 1'b0;
        chk("frz_count", {16'd0, stall_count}, 32'd5);
        chk_ctrl("frz_done", NONE);

        // Single-cycle redirect produces three flush cycles
        EX_redirect = 1'b1;
        chk_ctrl("rdr_0", RDR);
        tick();
        EX_redirect = 1'b0;
        chk_ctrl("rdr_1", RDR);
        tick();
        chk_ctrl("rdr_2", RDR);
        tick();
        chk_ctrl("rdr_end", NONE);

        // Redirect coinciding with load-use: squash wins, no PC stall
        EX_redirect = 1'b1;
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd7; ID_rs1 = 5'd7; ID_uses_rs1 = 1'b1;
        chk_ctrl("rdr_lu_0", RDR);
        tick();
        EX_redirect = 1'b0;
        chk_ctrl("rdr_lu_1", RDR);
        tick();
        chk_ctrl("rdr_lu_2", RDR);
        tick();
        clear_ld();
        chk_ctrl("rdr_lu_end", NONE);
        chk("rdr_count", {16'd0, stall_count}, 32'd5);

        // Freeze lands on the second flush cycle for two cycles
        EX_redirect = 1'b1;
        chk_ctrl("fif_rdr", RDR);
        tick();
        EX_redirect = 1'b0; MEM_req = 1'b1;
        chk_ctrl("fif_frz0", FRZ);
        tick();
        chk_ctrl("fif_frz1", FRZ);
        tick();
        MEM_ack = 1'b1;
        chk_ctrl("fif_release", RDR);
        tick();
        MEM_req = 1'b0; MEM_ack = 1'b0;
        chk_ctrl("fif_last", RDR);
        tick();
        chk_ctrl("fif_end", NONE);
        chk("fif_count", {16'd0, stall_count}, 32'd7);

        // Timeout sets after the 4th freeze edge and is sticky
        MEM_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            chk_ctrl($sformatf("to_frz_%0d", i), FRZ);
            chk($sformatf("to_flag_%0d", i), {31'd0, mem_timeout}, (i >= 5) ? 32'd1 : 32'd0);
            tick();
        end
        MEM_ack = 1'b1;
        chk_ctrl("to_ack", NONE);
        tick();
        MEM_req = 1'b0; MEM_ack = 1'b0;
        chk("to_sticky", {31'd0, mem_timeout}, 32'd1);
        chk("to_count", {16'd0, stall_count}, 32'd13);

        // Asynchronous reset in the middle of a memory wait
        MEM_req = 1'b1;
        tick();
        #2 reset = 1'b1;
        chk_ctrl("arst_ctrl", NONE);
        chk("arst_timeout", {31'd0, mem_timeout}, 32'd0);
        chk("arst_count", {16'd0, stall_count}, 32'd0);
        MEM_req = 1'b0;
        #2 reset = 1'b0;
        tick();
        chk_ctrl("post_rst_idle", NONE);
        chk("post_rst_count", {16'd0, stall_count}, 32'd0);
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd3; ID_rs2 = 5'd3; ID_uses_rs2 = 1'b1;
        chk_ctrl("post_rst_run_lu", LU);
        tick();
        clear_ld();
        chk("post_rst_count1", {16'd0, stall_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the hold and bubble controls of the PC, IF/ID, ID/EX (EX_stall), EX/MEM and MEM/WB registers.
- Resolves three hazard classes with fixed priority: memory freeze > control redirect > load-use.
- Holds a small FSM for multi-cycle data-memory waits and multi-cycle redirect flushes, plus a timeout detector and a stall performance counter.

Parameters:
FLUSH_CYCLES, 1, total cycles IF/ID flush and ID/EX bubble are asserted per redirect (1..15)
MEM_TIMEOUT, 255, freeze cycles after which mem_timeout sets (1..255)
CNT_W, 16, width of stall_count

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
ID_rs1  input  5  source reg 1 of instruction in ID
ID_rs2  input  5  source reg 2 of instruction in ID
ID_uses_rs1  input  1  ID instruction reads rs1
ID_uses_rs2  input  1  ID instruction reads rs2
ID_EX_rd  input  5  destination of instruction in EX
ID_EX_memread  input  1  instruction in EX is a load
EX_redirect  input  1  taken branch/jump resolved in EX this cycle
MEM_req  input  1  EX/MEM holds a load/store needing the data memory
MEM_ack  input  1  data memory completes the access this cycle
PC_stall  output  1  hold PC
IF_ID_stall  output  1  hold IF/ID
IF_ID_flush  output  1  load NOP into IF/ID
EX_stall  output  1  hold ID/EX
ID_EX_bubble  output  1  load zeroed controls into ID/EX
EX_MEM_stall  output  1  hold EX/MEM
MEM_WB_bubble  output  1  load zeroed controls into MEM/WB
mem_timeout  output  1  sticky: freeze exceeded MEM_TIMEOUT
stall_count  output  CNT_W  saturating count of cycles with PC_stall=1

Behaviour:
- Reset asserted: all outputs 0, state RUN, counters 0.
- Outputs are combinational from state and inputs (same-cycle). State and counters update on the clk rising edge.
- freeze = MEM_req & ~MEM_ack.
- load_use = ID_EX_memread & (ID_EX_rd!=0) & ((ID_uses_rs1 & ID_rs1==ID_EX_rd) | (ID_uses_rs2 & ID_rs2==ID_EX_rd)).
- redir = EX_redirect | (state==FLUSH).
- Priority 1, freeze:
  - PC_stall=IF_ID_stall=EX_stall=EX_MEM_stall=MEM_WB_bubble=1.
  - IF_ID_flush=ID_EX_bubble=0.
  - redirect and load_use are ignored. EX is held, so EX_redirect stays asserted and is acted on at release.
- Priority 2, redir (no freeze): IF_ID_flush=1, ID_EX_bubble=1, all stalls 0. load_use is ignored because the ID instruction is being squashed.
- Priority 3, load_use (no freeze, no redir): PC_stall=1, IF_ID_stall=1, ID_EX_bubble=1, others 0. Single cycle; it clears itself once the bubble reaches EX.
- Otherwise all control outputs are 0.
- FSM states: RUN, MEM_WAIT, FLUSH.
  - RUN: freeze -> MEM_WAIT. Else EX_redirect & FLUSH_CYCLES>1 -> FLUSH with flush_cnt=FLUSH_CYCLES-2. Else stay.
  - MEM_WAIT: stay while freeze. On MEM_ack -> RUN. The release cycle itself is not a freeze; outputs follow priorities 2/3.
  - FLUSH: freeze -> MEM_WAIT with flush_cnt retained; return to FLUSH after the ack. Else flush_cnt==0 -> RUN. Else flush_cnt-1. A new EX_redirect while in FLUSH reloads flush_cnt=FLUSH_CYCLES-2.
  - Implement the MEM_WAIT return target with a saved-state bit.
- wait_cnt (8 bit):
  - Clears on any non-freeze cycle; increments each freeze cycle, saturating at 255.
  - When wait_cnt==MEM_TIMEOUT-1 and freeze holds, mem_timeout sets on that edge and stays set until reset.
- stall_count: +1 on each edge where PC_stall=1; saturates at all-ones.
- Reset mid-freeze or mid-flush: immediate return to RUN, outputs 0, mem_timeout cleared.

Test Plan:
1. Load-use: ID_EX_memread=1, ID_EX_rd=5, ID_rs1=5, ID_uses_rs1=1, no mem activity -> PC_stall=IF_ID_stall=ID_EX_bubble=1 for exactly 1 cycle. Repeat with rd=0 or ID_uses_rs1=0 -> no stall.
2. Memory freeze: MEM_req=1 with MEM_ack=0 for 3 cycles, then ack -> stall group + MEM_WB_bubble high for 3 cycles, 0 on the ack cycle, stall_count=3.
3. Redirect, FLUSH_CYCLES=3: EX_redirect pulse 1 cycle -> IF_ID_flush=ID_EX_bubble=1 for 3 consecutive cycles, then 0. The same pulse coinciding with load_use gives no PC_stall.
4. Freeze during flush (FLUSH_CYCLES=3): MEM_req without ack arrives in the 2nd flush cycle for 2 cycles -> flush outputs 0 during the freeze; remaining 2 flush cycles (release + 1) follow.
5. Timeout, MEM_TIMEOUT=4: freeze held 6 cycles -> mem_timeout rises after the 4th freeze edge and stays 1 after the ack. Only reset clears it.
6. Async reset asserted mid-MEM_WAIT between clock edges -> all outputs 0 immediately. After release with no inputs active, state is RUN and stall_count=0.
